i2s_capture_ctrl: RTL and testbench

//  SPI-command controller that sequences the I2S microphone capture path:

---
 rtl/i2s_ctrl_pkg.sv | 47 ++++
 rtl/i2s_capture_ctrl_if.sv | 41 ++++
 rtl/i2s_capture_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_i2s_capture_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_ctrl_pkg.sv
// i2s_capture_ctrl shared types.
// Command codes, FSM states, status byte layout.
package i2s_ctrl_pkg;

  typedef enum logic [7:0] {
    CMD_START      = 8'h01,
    CMD_STOP       = 8'h02,
    CMD_FLUSH      = 8'h03,
    CMD_SET_REDUCE = 8'h04,
    CMD_STATUS     = 8'h05,
    CMD_READ       = 8'h06
  } cmd_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ARG,
    STATUS,
    READ,
    DISCARD
  } state_e;

  localparam int ST_OVF     = 7;
  localparam int ST_FULL    = 6;
  localparam int ST_EMPTY   = 5;
  localparam int ST_CAP     = 4;
  localparam int ST_RED_MSB = 3;
  localparam int ST_RED_LSB = 0;

  function automatic logic [7:0] status_byte(
    input logic       ovf,
    input logic       full,
    input logic       empty,
    input logic       cap,
    input logic [3:0] red
  );
    logic [7:0] b;
    b = '0;
    b[ST_OVF]   = ovf;
    b[ST_FULL]  = full;
    b[ST_EMPTY] = empty;
    b[ST_CAP]   = cap;
    b[ST_RED_MSB:ST_RED_LSB] = red;
    return b;
  endfunction

endpackage

// File: rtl/i2s_capture_ctrl_if.sv
// SPI byte port and FIFO read port of the
// capture controller.
interface i2s_capture_ctrl_if #(
  parameter int COUNT_W = 16
) ();

  logic               spi_active;
  logic               spi_rx_valid;
  logic [7:0]         spi_rx_data;
  logic [7:0]         spi_tx_data;
  logic               fifo_rd_en;
  logic [7:0]         fifo_rd_data;
  logic               fifo_empty;
  logic               fifo_full;
  logic [COUNT_W-1:0] fifo_count;

  modport master (
    input  spi_active,
    input  spi_rx_valid,
    input  spi_rx_data,
    output spi_tx_data,
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty,
    input  fifo_full,
    input  fifo_count
  );

  modport slave (
    output spi_active,
    output spi_rx_valid,
    output spi_rx_data,
    input  spi_tx_data,
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty,
    output fifo_full,
    output fifo_count
  );

endinterface

// File: rtl/i2s_capture_ctrl.sv
// SPI command controller for the I2S capture
// path: gating, decimation, flush, status, read.
module i2s_capture_ctrl
  import i2s_ctrl_pkg::*;
#(
  parameter int         COUNT_W        = 16,
  parameter logic [3:0] DEFAULT_REDUCE = 4'd2,
  parameter logic [7:0] ID_BYTE        = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  i2s_capture_ctrl_if.master bus,
  output logic               cap_en,
  output logic [3:0]         cap_reduce,
  output logic               fifo_flush,
  output logic               overflow
);

  state_e             state_q, state_d;
  logic [7:0]         tx_q, tx_d;
  logic               rd_en_q, rd_en_d;
  logic               rd_pend_q;
  logic               cap_q, cap_d;
  logic [3:0]         red_q, red_d;
  logic               flush_q, flush_d;
  logic               ovf_q, ovf_d, ovf_clr;
  logic               pf_valid_q, pf_valid_d;
  logic [7:0]         pf_data_q, pf_data_d;
  logic [15:0]        snap_q, snap_d;
  logic [1:0]         idx_q, idx_d;
  logic [COUNT_W-1:0] cnt_w;
  logic [15:0]        cnt16;
  logic [7:0]         rx;
  logic               rxv;

  assign cnt_w = bus.fifo_count;
  assign cnt16 = 16'(cnt_w);
  assign rx    = bus.spi_rx_data;
  assign rxv   = bus.spi_rx_valid;

  assign bus.spi_tx_data = tx_q;
  assign bus.fifo_rd_en  = rd_en_q;
  assign cap_en          = cap_q;
  assign cap_reduce      = red_q;
  assign fifo_flush      = flush_q;
  assign overflow        = ovf_q;

  // Register all controller state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tx_q       <= ID_BYTE;
      rd_en_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      cap_q      <= 1'b0;
      red_q      <= DEFAULT_REDUCE;
      flush_q    <= 1'b0;
      ovf_q      <= 1'b0;
      pf_valid_q <= 1'b0;
      pf_data_q  <= 8'h00;
      snap_q     <= 16'h0000;
      idx_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rd_en_q    <= rd_en_d;
      rd_pend_q  <= rd_en_q;
      cap_q      <= cap_d;
      red_q      <= red_d;
      flush_q    <= flush_d;
      ovf_q      <= ovf_d;
      pf_valid_q <= pf_valid_d;
      pf_data_q  <= pf_data_d;
      snap_q     <= snap_d;
      idx_q      <= idx_d;
    end
  end

  // Command decode, next state and next outputs.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rd_en_d    = 1'b0;
    cap_d      = cap_q;
    red_d      = red_q;
    flush_d    = 1'b0;
    ovf_clr    = 1'b0;
    pf_valid_d = pf_valid_q;
    pf_data_d  = pf_data_q;
    snap_d     = snap_q;
    idx_d      = idx_q;

    // A popped byte is always kept, even if
    // the frame was dropped while in flight.
    if (rd_pend_q) begin
      pf_data_d  = bus.fifo_rd_data;
      pf_valid_d = 1'b1;
      if (state_q == READ)
        tx_d = bus.fifo_rd_data;
    end

    if (!bus.spi_active) begin
      state_d = IDLE;
      tx_d    = ID_BYTE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = CMD;
          tx_d    = ID_BYTE;
        end
        CMD: begin
          if (rxv) begin
            tx_d    = 8'h00;
            state_d = DISCARD;
            unique case (1'b1)
              (rx == CMD_START): cap_d = 1'b1;
              (rx == CMD_STOP):  cap_d = 1'b0;
              (rx == CMD_FLUSH): begin
                flush_d    = 1'b1;
                ovf_clr    = 1'b1;
                pf_valid_d = 1'b0;
              end
              (rx == CMD_SET_REDUCE): state_d = ARG;
              (rx == CMD_STATUS): begin
                state_d = STATUS;
                snap_d  = cnt16;
                idx_d   = 2'd1;
                tx_d    = status_byte(ovf_q,
                            bus.fifo_full,
                            bus.fifo_empty,
                            cap_q, red_q);
              end
              (rx == CMD_READ): begin
                state_d = READ;
                if (pf_valid_q)
                  tx_d = pf_data_q;
                else if (!bus.fifo_empty)
                  rd_en_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        ARG: begin
          if (rxv) begin
            if (rx[3:0] != 4'd0)
              red_d = rx[3:0];
            state_d = DISCARD;
            tx_d    = 8'h00;
          end
        end
        STATUS: begin
          if (rxv) begin
            unique case (idx_q)
              2'd1:    tx_d = snap_q[15:8];
              2'd2:    tx_d = snap_q[7:0];
              default: tx_d = 8'h00;
            endcase
            if (idx_q != 2'd3)
              idx_d = idx_q + 2'd1;
          end
        end
        READ: begin
          if (rxv && !rd_en_q && !rd_pend_q) begin
            pf_valid_d = 1'b0;
            if (!bus.fifo_empty)
              rd_en_d = 1'b1;
            else
              tx_d = 8'h00;
          end
        end
        DISCARD: begin
          if (rxv)
            tx_d = 8'h00;
        end
        default: state_d = IDLE;
      endcase
    end

    if (flush_d)
      rd_en_d = 1'b0;

    // Set wins over clear.
    ovf_d = (ovf_q & ~ovf_clr)
          | (cap_q & bus.fifo_full);
  end

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Bench for i2s_capture_ctrl: vector table of
// SPI frames plus hand-written corner sequences.
module tb_i2s_capture_ctrl;
  import i2s_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2s_capture_ctrl_if #(.COUNT_W(16)) bus ();

  logic       cap_en;
  logic [3:0] cap_reduce;
  logic       fifo_flush;
  logic       overflow;

  i2s_capture_ctrl #(
    .COUNT_W(16),
    .DEFAULT_REDUCE(4'd2),
    .ID_BYTE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cap_en(cap_en),
    .cap_reduce(cap_reduce),
    .fifo_flush(fifo_flush),
    .overflow(overflow)
  );

  logic [7:0]  fq[$];
  int          fq_n = 0;
  int          pops = 0;
  int          flushes = 0;
  int          underflow = 0;
  int          both_err = 0;
  logic        push_v = 1'b0;
  logic [7:0]  push_d = 8'h00;
  logic        clr_req = 1'b0;
  logic        full_f = 1'b0;
  logic        cnt_ovr = 1'b0;
  logic [15:0] cnt_val = 16'h0000;

  assign bus.fifo_full  = full_f;
  assign bus.fifo_count = cnt_ovr ? cnt_val : 16'(fq_n);
  assign bus.fifo_empty = cnt_ovr ? (cnt_val == 16'd0)
                                  : (fq_n == 0);

  // Sample FIFO model behind the controller.
  always @(posedge clk) begin
    if (fifo_flush) begin
      fq.delete();
      flushes <= flushes + 1;
      if (bus.fifo_rd_en) both_err <= both_err + 1;
    end else if (bus.fifo_rd_en) begin
      if (fq.size() == 0)
        underflow <= underflow + 1;
      else begin
        bus.fifo_rd_data <= fq.pop_front();
        pops <= pops + 1;
      end
    end
    if (clr_req) fq.delete();
    if (push_v) fq.push_back(push_d);
    fq_n <= fq.size();
  end

  int         n_chk = 0;
  int         n_pass = 0;
  string      cur = "reset";
  logic [7:0] exp_q[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got 0x%0h want 0x%0h",
                  cur, nm, act, exp);
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(posedge clk); #1;
    push_v = 1'b1;
    push_d = d;
    @(posedge clk); #1;
    push_v = 1'b0;
  endtask

  task automatic frame_begin();
    @(posedge clk); #1;
    bus.spi_active = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  task automatic frame_end();
    repeat (6) @(posedge clk); #1;
    bus.spi_active = 1'b0;
    repeat (3) @(posedge clk);
    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Compare the byte shifted out in this slot,
  // then deliver the received byte.
  task automatic xfer(input logic [7:0] d);
    logic [7:0] e;
    repeat (4) @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_chk++;
      $display("FAIL %s/sb_underrun: tx 0x%0h unexpected",
               cur, bus.spi_tx_data);
    end else begin
      e = exp_q.pop_front();
      chk("tx_byte", 32'(bus.spi_tx_data), 32'(e));
    end
    @(posedge clk); #1;
    bus.spi_rx_valid = 1'b1;
    bus.spi_rx_data  = d;
    @(posedge clk); #1;
    bus.spi_rx_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] r0,
                       input logic [7:0] t0);
    exp_q.push_back(t0);
    frame_begin();
    xfer(r0);
    frame_end();
  endtask

  typedef struct {
    string           name;
    int              pre_n;
    logic [0:3][7:0] pre;
    int              n;
    logic [0:5][7:0] rx;
    logic [0:5][7:0] tx;
    logic            cap;
    logic [3:0]      red;
    int              pops;
    int              fl;
  } vec_t;

  function automatic vec_t mk(
    input string nm, input int pre_n,
    input logic [0:3][7:0] pre, input int n,
    input logic [0:5][7:0] rx,
    input logic [0:5][7:0] tx,
    input logic cap, input logic [3:0] red,
    input int np, input int fl);
    vec_t v;
    v.name = nm; v.pre_n = pre_n; v.pre = pre;
    v.n = n; v.rx = rx; v.tx = tx; v.cap = cap;
    v.red = red; v.pops = np; v.fl = fl;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    int p0;
    int f0;

    tbl[0]  = mk("set_reduce7", 0, 32'h0, 2,
      48'h04_07_00_00_00_00, 48'hA5_00_00_00_00_00,
      1'b0, 4'd7, 0, 0);
    tbl[1]  = mk("start", 0, 32'h0, 1,
      48'h01_00_00_00_00_00, 48'hA5_00_00_00_00_00,
      1'b1, 4'd7, 0, 0);
    tbl[2]  = mk("reduce0_ignored", 0, 32'h0, 2,
      48'h04_00_00_00_00_00, 48'hA5_00_00_00_00_00,
      1'b1, 4'd7, 0, 0);
    tbl[3]  = mk("start_noop", 0, 32'h0, 1,
      48'h01_00_00_00_00_00, 48'hA5_00_00_00_00_00,
      1'b1, 4'd7, 0, 0);
    tbl[4]  = mk("stop", 0, 32'h0, 1,
      48'h02_00_00_00_00_00, 48'hA5_00_00_00_00_00,
      1'b0, 4'd7, 0, 0);
    tbl[5]  = mk("stop_noop", 0, 32'h0, 1,
      48'h02_00_00_00_00_00, 48'hA5_00_00_00_00_00,
      1'b0, 4'd7, 0, 0);
    tbl[6]  = mk("read3", 3, 32'h10_11_12_00, 5,
      48'h06_00_00_00_00_00, 48'hA5_10_11_12_00_00,
      1'b0, 4'd7, 3, 0);
    tbl[7]  = mk("read_split_a", 2, 32'h20_21_00_00, 2,
      48'h06_00_00_00_00_00, 48'hA5_20_00_00_00_00,
      1'b0, 4'd7, 2, 0);
    tbl[8]  = mk("read_split_b", 0, 32'h0, 3,
      48'h06_00_00_00_00_00, 48'hA5_21_00_00_00_00,
      1'b0, 4'd7, 0, 0);
    tbl[9]  = mk("unknown_cmd", 1, 32'h33_00_00_00, 4,
      48'h7E_01_03_06_00_00, 48'hA5_00_00_00_00_00,
      1'b0, 4'd7, 0, 0);
    tbl[10] = mk("flush", 0, 32'h0, 1,
      48'h03_00_00_00_00_00, 48'hA5_00_00_00_00_00,
      1'b0, 4'd7, 0, 1);
    tbl[11] = mk("read_empty", 0, 32'h0, 3,
      48'h06_00_00_00_00_00, 48'hA5_00_00_00_00_00,
      1'b0, 4'd7, 0, 0);
    tbl[12] = mk("status_idle", 0, 32'h0, 5,
      48'h05_00_00_00_00_00, 48'hA5_27_00_00_00_00,
      1'b0, 4'd7, 0, 0);

    rst = 1'b1;
    bus.spi_active   = 1'b0;
    bus.spi_rx_valid = 1'b0;
    bus.spi_rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(bus.spi_tx_data), 32'hA5);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("rst_cap", 32'(cap_en), 32'd0);
    chk("rst_red", 32'(cap_reduce), 32'd2);
    chk("rst_flush", 32'(fifo_flush), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    cur = "rst_mid_read";
    push_byte(8'hAA);
    push_byte(8'hBB);
    exp_q.push_back(8'hA5);
    frame_begin();
    xfer(8'h06);
    repeat (5) @(posedge clk);
    chk("pf_before", 32'(dut.pf_valid_q), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("tx", 32'(bus.spi_tx_data), 32'hA5);
    chk("rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("red", 32'(cap_reduce), 32'd2);
    chk("flush", 32'(fifo_flush), 32'd0);
    chk("state", 32'(dut.state_q), 32'(IDLE));
    chk("pf_valid", 32'(dut.pf_valid_q), 32'd0);
    bus.spi_active = 1'b0;
    @(posedge clk); #1;
    clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 13; i++) begin
      cur = tbl[i].name;
      for (int k = 0; k < tbl[i].pre_n; k++)
        push_byte(tbl[i].pre[k]);
      repeat (2) @(posedge clk);
      p0 = pops;
      f0 = flushes;
      for (int k = 0; k < tbl[i].n; k++)
        exp_q.push_back(tbl[i].tx[k]);
      frame_begin();
      for (int k = 0; k < tbl[i].n; k++)
        xfer(tbl[i].rx[k]);
      frame_end();
      chk("cap_en", 32'(cap_en), 32'(tbl[i].cap));
      chk("reduce", 32'(cap_reduce), 32'(tbl[i].red));
      chk("pops", 32'(pops - p0), 32'(tbl[i].pops));
      chk("flushes", 32'(flushes - f0), 32'(tbl[i].fl));
      chk("ovf", 32'(overflow), 32'd0);
    end

    cur = "overflow";
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    frame_begin();
    xfer(8'h04);
    xfer(8'h02);
    frame_end();
    send1(8'h01, 8'hA5);
    chk("red2", 32'(cap_reduce), 32'd2);
    chk("cap1", 32'(cap_en), 32'd1);
    @(posedge clk); #1;
    full_f = 1'b1;
    @(posedge clk); #1;
    full_f = 1'b0;
    @(negedge clk);
    chk("ovf_set", 32'(overflow), 32'd1);

    cur = "status";
    full_f  = 1'b1;
    cnt_ovr = 1'b1;
    cnt_val = 16'h0123;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hD2);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h23);
    frame_begin();
    xfer(8'h05);
    cnt_val = 16'h0456;
    xfer(8'h00);
    xfer(8'h00);
    xfer(8'h00);
    frame_end();

    cur = "flush_ovf";
    f0 = flushes;
    send1(8'h03, 8'hA5);
    chk("flush_pulse", 32'(flushes - f0), 32'd1);
    chk("set_wins", 32'(overflow), 32'd1);
    full_f  = 1'b0;
    cnt_ovr = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sticky", 32'(overflow), 32'd1);
    f0 = flushes;
    send1(8'h03, 8'hA5);
    chk("flush_pulse2", 32'(flushes - f0), 32'd1);
    chk("ovf_clr", 32'(overflow), 32'd0);
    chk("cap_kept", 32'(cap_en), 32'd1);

    cur = "cs_drop";
    exp_q.push_back(8'hA5);
    frame_begin();
    xfer(8'h04);
    frame_end();
    chk("red_kept", 32'(cap_reduce), 32'd2);
    send1(8'h0C, 8'hA5);
    chk("red_not_arg", 32'(cap_reduce), 32'd2);
    send1(8'h02, 8'hA5);
    chk("cap_stop", 32'(cap_en), 32'd0);

    cur = "global";
    chk("underflow", 32'(underflow), 32'd0);
    chk("rd_and_flush", 32'(both_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
